// File: rtl/mw_load_stage_pkg.sv
// Shared constants for the M/W load path.
// Holds the load opcodes, the text-segment base used as the idle/bubble PC,
// and the byte-offset encoding. The data-memory store side reuses these.
package mw_load_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_LB  = 6'd32;
  localparam logic [5:0] OP_LBU = 6'd36;
  localparam logic [5:0] OP_LH  = 6'd33;
  localparam logic [5:0] OP_LHU = 6'd37;

  // Byte offset inside a 32-bit word (little-endian lane number).
  typedef enum logic [1:0] {
    BOFF_0 = 2'd0,
    BOFF_1 = 2'd1,
    BOFF_2 = 2'd2,
    BOFF_3 = 2'd3
  } boff_e;

endpackage

// File: rtl/mw_load_stage_if.sv
// M/W stage bus.
// master: upstream M stage / bench; drives M-side fields and pipeline control,
//         receives the W-stage write port.
// slave : mw_load_stage; receives M-side fields, drives the W-stage write port.
interface mw_load_stage_if;

  logic        en;
  logic        flush;
  logic [31:0] pc_m;
  logic [5:0]  opcode_m;
  logic [1:0]  byte_m;
  logic [31:0] alu_m;
  logic [31:0] dm_dout_m;
  logic        memtoreg_m;
  logic        regwrite_m;
  logic [4:0]  wa_m;

  logic [31:0] pc_w;
  logic [4:0]  wa_w;
  logic        we_w;
  logic [31:0] wd_w;
  logic        valid_w;
  logic        adel_w;

  modport master (
    output en, flush, pc_m, opcode_m, byte_m, alu_m, dm_dout_m,
           memtoreg_m, regwrite_m, wa_m,
    input  pc_w, wa_w, we_w, wd_w, valid_w, adel_w
  );

  modport slave (
    input  en, flush, pc_m, opcode_m, byte_m, alu_m, dm_dout_m,
           memtoreg_m, regwrite_m, wa_m,
    output pc_w, wa_w, we_w, wd_w, valid_w, adel_w
  );

endinterface

// File: rtl/mw_load_stage_load_ext.sv
// Combinational load formatter.
// Ports:
//   i_opcode : load opcode (unknown opcodes behave as lw)
//   i_byte   : byte offset within the word
//   i_word   : word read from data memory
//   o_data   : extended load result, 0 when misaligned
//   o_adel   : misaligned-load flag
module mw_load_stage_load_ext
  import mw_load_stage_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  boff_e       i_byte,
  input  logic [31:0] i_word,
  output logic [31:0] o_data,
  output logic        o_adel
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_byte)
      BOFF_0:  w_byte = i_word[7:0];
      BOFF_1:  w_byte = i_word[15:8];
      BOFF_2:  w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_byte[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = '0;
    o_adel = 1'b0;
    case (i_opcode)
      OP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU: o_data = {24'd0, w_byte};
      OP_LH, OP_LHU: begin
        if (i_byte[0]) o_adel = 1'b1;
        else if (i_opcode == OP_LH) o_data = {{16{w_half[15]}}, w_half};
        else o_data = {16'd0, w_half};
      end
      default: begin
        if (i_byte != BOFF_0) o_adel = 1'b1;
        else o_data = i_word;
      end
    endcase
  end

endmodule

// File: rtl/mw_load_stage.sv
// M/W pipeline register plus write-back load formatter.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : mw_load_stage_if.slave (M-side capture fields, en/flush,
//           W-side GRF write port and status)
// Write-back data and enable are combinational from the W registers so the
// forwarding network sees them in the same cycle as the GRF.
module mw_load_stage
  import mw_load_stage_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mw_load_stage_if.slave bus
);

  logic [31:0] r_pc;
  logic [5:0]  r_opcode;
  boff_e       r_byte;
  logic [31:0] r_alu;
  logic [31:0] r_dout;
  logic        r_memtoreg;
  logic        r_regwrite;
  logic [4:0]  r_wa;
  logic        r_valid;

  logic [31:0] w_ext_data;
  logic        w_ext_adel;
  logic        w_adel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || (bus.flush)) begin
      // Bubble and reset share one image: idle PC, everything else zero,
      // so a flushed slot also presents wd_w=0.
      r_pc       <= RESET_PC;
      r_opcode   <= '0;
      r_byte     <= BOFF_0;
      r_alu      <= '0;
      r_dout     <= '0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
      r_wa       <= '0;
      r_valid    <= 1'b0;
    end else if (bus.en) begin
      r_pc       <= bus.pc_m;
      r_opcode   <= bus.opcode_m;
      r_byte     <= boff_e'(bus.byte_m);
      r_alu      <= bus.alu_m;
      r_dout     <= bus.dm_dout_m;
      r_memtoreg <= bus.memtoreg_m;
      r_regwrite <= bus.regwrite_m;
      r_wa       <= bus.wa_m;
      r_valid    <= 1'b1;
    end
  end

  mw_load_stage_load_ext u_load_ext (
    .i_opcode (r_opcode),
    .i_byte   (r_byte),
    .i_word   (r_dout),
    .o_data   (w_ext_data),
    .o_adel   (w_ext_adel)
  );

  assign w_adel      = r_memtoreg & w_ext_adel;

  assign bus.pc_w    = r_pc;
  assign bus.wa_w    = r_wa;
  assign bus.valid_w = r_valid;
  assign bus.adel_w  = w_adel;
  assign bus.wd_w    = r_memtoreg ? w_ext_data : r_alu;
  assign bus.we_w    = r_regwrite & r_valid & ~w_adel & (r_wa != 5'd0);

endmodule

// File: tb/tb_mw_load_stage.sv
module tb_mw_load_stage;
  import mw_load_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  mw_load_stage_if bus ();

  mw_load_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference W-stage contents
  logic [31:0] m_pc, m_alu, m_d;
  logic [5:0]  m_op;
  logic [1:0]  m_b;
  logic        m_mem, m_rw, m_valid;
  logic [4:0]  m_wa;

  function automatic void model_reset();
    m_pc = RESET_PC; m_alu = 0; m_d = 0; m_op = 0; m_b = 0;
    m_mem = 0; m_rw = 0; m_valid = 0; m_wa = 0;
  endfunction

  // Expected write port from the architectural load rules.
  task automatic ref_eval(output logic [31:0] wd, output logic we, output logic adel);
    longint unsigned v;
    wd = 0; adel = 0;
    if (!m_mem) begin
      wd = m_alu;
    end else if (m_op == OP_LB || m_op == OP_LBU) begin
      v = ({32'd0, m_d} >> (8 * m_b)) % 256;
      if (m_op == OP_LB && v >= 128) v = v + 64'hFFFF_FF00;
      wd = v[31:0];
    end else if (m_op == OP_LH || m_op == OP_LHU) begin
      if (m_b % 2 == 1) adel = 1;
      else begin
        v = ({32'd0, m_d} >> (8 * m_b)) % 65536;
        if (m_op == OP_LH && v >= 32768) v = v + 64'hFFFF_0000;
        wd = v[31:0];
      end
    end else begin
      if (m_b != 0) adel = 1;
      else wd = m_d;
    end
    we = m_rw && m_valid && !adel && (m_wa != 0);
  endtask

  task automatic drive(input logic [5:0] op, input logic [1:0] b, input logic [31:0] alu,
                       input logic [31:0] d, input logic mem, input logic rw,
                       input logic [4:0] wa, input logic [31:0] pc);
    bus.opcode_m = op; bus.byte_m = b; bus.alu_m = alu; bus.dm_dout_m = d;
    bus.memtoreg_m = mem; bus.regwrite_m = rw; bus.wa_m = wa; bus.pc_m = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    if (bus.flush) model_reset();
    else if (bus.en) begin
      m_pc = bus.pc_m; m_op = bus.opcode_m; m_b = bus.byte_m; m_alu = bus.alu_m;
      m_d = bus.dm_dout_m; m_mem = bus.memtoreg_m; m_rw = bus.regwrite_m;
      m_wa = bus.wa_m; m_valid = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.en = 1'b0; bus.flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    n_vec++; if (bus.pc_w !== RESET_PC) begin n_err++; $display("FAIL rst_pc got %h want %h", bus.pc_w, RESET_PC); end
    n_vec++; if ({bus.we_w, bus.valid_w, bus.adel_w} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b want 000", {bus.we_w, bus.valid_w, bus.adel_w}); end
    n_vec++; if ({bus.wd_w, bus.wa_w} !== 37'd0) begin n_err++; $display("FAIL rst_data got %h/%0d want 0/0", bus.wd_w, bus.wa_w); end
    @(negedge clk) reset = 1'b0;
    // Valid lw, then reset mid-cycle
    bus.en = 1'b1;
    drive(OP_LW, 0, 32'h40, 32'hCAFE_F00D, 1, 1, 5'd5, 32'h0000_3010);
    tick();
    n_vec++; if (bus.we_w !== 1'b1 || bus.wd_w !== 32'hCAFE_F00D) begin n_err++; $display("FAIL rst_pre_lw got we=%b wd=%h want 1/cafef00d", bus.we_w, bus.wd_w); end
    #3 reset = 1'b1;
    model_reset();
    #1;
    n_vec++; if (bus.we_w !== 1'b0 || bus.valid_w !== 1'b0 || bus.pc_w !== RESET_PC) begin n_err++; $display("FAIL rst_async got we=%b valid=%b pc=%h want 0/0/00003000", bus.we_w, bus.valid_w, bus.pc_w); end
    @(negedge clk) reset = 1'b0;
    bus.en = 1'b0;
  endtask

  task automatic test_formats();
    bus.en = 1'b1; bus.flush = 1'b0;
    drive(OP_LB, 2'd1, 32'h101, 32'h8899_AABB, 1, 1, 5'd7, 32'h3020); tick();
    n_vec++; if (bus.wd_w !== 32'hFFFF_FFAA) begin n_err++; $display("FAIL lb_b1 got %h want ffffffaa", bus.wd_w); end
    drive(OP_LBU, 2'd3, 32'h103, 32'h8899_AABB, 1, 1, 5'd7, 32'h3024); tick();
    n_vec++; if (bus.wd_w !== 32'h0000_0088) begin n_err++; $display("FAIL lbu_b3 got %h want 00000088", bus.wd_w); end
    drive(OP_LH, 2'd2, 32'h102, 32'h8899_AABB, 1, 1, 5'd7, 32'h3028); tick();
    n_vec++; if (bus.wd_w !== 32'hFFFF_8899) begin n_err++; $display("FAIL lh_b2 got %h want ffff8899", bus.wd_w); end
    drive(OP_LHU, 2'd0, 32'h100, 32'h8899_AABB, 1, 1, 5'd7, 32'h302C); tick();
    n_vec++; if (bus.wd_w !== 32'h0000_AABB || bus.we_w !== 1'b1) begin n_err++; $display("FAIL lhu_b0 got %h we=%b want 0000aabb we=1", bus.wd_w, bus.we_w); end
  endtask

  task automatic test_misaligned();
    bus.en = 1'b1; bus.flush = 1'b0;
    drive(OP_LW, 2'd2, 32'h202, 32'h1234_5678, 1, 1, 5'd5, 32'h3030); tick();
    n_vec++; if ({bus.adel_w, bus.we_w} !== 2'b10 || bus.wd_w !== 32'd0) begin n_err++; $display("FAIL adel_lw got adel=%b we=%b wd=%h want 1/0/0", bus.adel_w, bus.we_w, bus.wd_w); end
    drive(OP_LH, 2'd3, 32'h203, 32'h1234_5678, 1, 1, 5'd5, 32'h3034); tick();
    n_vec++; if ({bus.adel_w, bus.we_w} !== 2'b10 || bus.wd_w !== 32'd0) begin n_err++; $display("FAIL adel_lh got adel=%b we=%b wd=%h want 1/0/0", bus.adel_w, bus.we_w, bus.wd_w); end
  endtask

  task automatic test_alu();
    bus.en = 1'b1; bus.flush = 1'b0;
    drive(6'd0, 2'd0, 32'h1234_5678, 32'hDEAD_BEEF, 0, 1, 5'd0, 32'h3038); tick();
    n_vec++; if (bus.wd_w !== 32'h1234_5678 || bus.we_w !== 1'b0) begin n_err++; $display("FAIL alu_wa0 got wd=%h we=%b want 12345678/0", bus.wd_w, bus.we_w); end
    drive(6'd0, 2'd0, 32'h1234_5678, 32'hDEAD_BEEF, 0, 1, 5'd8, 32'h303C); tick();
    n_vec++; if (bus.wd_w !== 32'h1234_5678 || bus.we_w !== 1'b1 || bus.adel_w !== 1'b0) begin n_err++; $display("FAIL alu_wa8 got wd=%h we=%b adel=%b want 12345678/1/0", bus.wd_w, bus.we_w, bus.adel_w); end
  endtask

  task automatic test_hold_flush();
    bus.en = 1'b1; bus.flush = 1'b0;
    drive(OP_LW, 2'd0, 32'h300, 32'h0BAD_CAFE, 1, 1, 5'd9, 32'h3040); tick();
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(6'($urandom), 2'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
            5'($urandom), $urandom);
      tick();
      n_vec++; if (bus.wd_w !== 32'h0BAD_CAFE || bus.wa_w !== 5'd9 || bus.we_w !== 1'b1 || bus.pc_w !== 32'h3040) begin
        n_err++; $display("FAIL hold_%0d got wd=%h wa=%0d we=%b pc=%h want 0badcafe/9/1/00003040", i, bus.wd_w, bus.wa_w, bus.we_w, bus.pc_w); end
    end
    bus.en = 1'b1; bus.flush = 1'b1;
    drive(OP_LW, 2'd0, 32'h304, 32'h7777_7777, 1, 1, 5'd10, 32'h3044); tick();
    n_vec++; if (bus.valid_w !== 1'b0 || bus.we_w !== 1'b0 || bus.pc_w !== RESET_PC) begin n_err++; $display("FAIL flush got valid=%b we=%b pc=%h want 0/0/00003000", bus.valid_w, bus.we_w, bus.pc_w); end
    bus.flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words[0] = 32'hA000_0002; words[1] = 32'hB000_0003; words[2] = 32'hC000_0004;
    bus.en = 1'b1; bus.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(OP_LW, 2'd0, 32'h400 + 32'(4 * i), words[i], 1, 1, 5'(i + 2), 32'h3050 + 32'(4 * i));
      tick();
      n_vec++; if (bus.wa_w !== 5'(i + 2) || bus.wd_w !== words[i] || bus.we_w !== 1'b1) begin
        n_err++; $display("FAIL b2b_%0d got wa=%0d wd=%h we=%b want %0d/%h/1", i, bus.wa_w, bus.wd_w, bus.we_w, i + 2, words[i]); end
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [7];
    logic [31:0] e_wd;
    logic        e_we, e_adel;
    ops[0] = OP_LW; ops[1] = OP_LB; ops[2] = OP_LBU; ops[3] = OP_LH;
    ops[4] = OP_LHU; ops[5] = 6'd0; ops[6] = 6'd43;
    for (int i = 0; i < 300; i++) begin
      bus.en    = ($urandom_range(0, 3) != 0);
      bus.flush = ($urandom_range(0, 11) == 0);
      drive(ops[$urandom_range(0, 6)], 2'($urandom), $urandom, $urandom, 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom);
      tick();
      ref_eval(e_wd, e_we, e_adel);
      n_vec++; if (bus.wd_w !== e_wd) begin n_err++; $display("FAIL rnd_wd_%0d got %h want %h", i, bus.wd_w, e_wd); end
      n_vec++; if (bus.we_w !== e_we || bus.adel_w !== e_adel) begin n_err++; $display("FAIL rnd_flags_%0d got we=%b adel=%b want %b/%b", i, bus.we_w, bus.adel_w, e_we, e_adel); end
      n_vec++; if (bus.pc_w !== m_pc || bus.wa_w !== m_wa || bus.valid_w !== m_valid) begin
        n_err++; $display("FAIL rnd_reg_%0d got pc=%h wa=%0d valid=%b want %h/%0d/%b", i, bus.pc_w, bus.wa_w, bus.valid_w, m_pc, m_wa, m_valid); end
    end
    bus.flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_formats();
    test_misaligned();
    test_alu();
    test_hold_flush();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mw_load_stage.md
Name: mw_load_stage

Overview:
M/W pipeline register plus write-back load formatter, sitting directly downstream of the data memory.
- Captures the M-stage word read (dm_dout_m), ALU result and control at the clock edge.
- Selects and extends the addressed byte/halfword for lb/lbu/lh/lhu/lw.
- Presents the final register-file write port to the W stage and the W-to-D/E/M forwarding network.
- Flags misaligned loads instead of writing corrupt data.

Parameters:
RESET_PC, 32'h00003000, value of pc_w after reset or flush (text segment base)
OP_LW, 6'd35, lw opcode
OP_LB, 6'd32, lb opcode
OP_LBU, 6'd36, lbu opcode
OP_LH, 6'd33, lh opcode
OP_LHU, 6'd37, lhu opcode

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
en  in  1  pipeline advance; 0 holds all registers
flush  in  1  synchronous bubble insert; wins over en
pc_m  in  32  M-stage instruction PC
opcode_m  in  6  M-stage opcode
byte_m  in  2  ALU address bits [1:0]
alu_m  in  32  M-stage ALU result (non-load write data)
dm_dout_m  in  32  word read from data memory at alu_m[13:2]
memtoreg_m  in  1  1 = write-back data comes from memory
regwrite_m  in  1  M-stage instruction writes GRF
wa_m  in  5  destination register
pc_w  out  32  W-stage PC (for GRF $display)
wa_w  out  5  W destination register
we_w  out  1  GRF write enable
wd_w  out  32  GRF write data (formatted)
valid_w  out  1  W stage holds a real instruction
adel_w  out  1  misaligned load in W

Behaviour:
- Reset, asynchronous: pc_w=RESET_PC, and every other register = 0. This gives we_w=0, wd_w=0, wa_w=0, valid_w=0, adel_w=0.
- Reset takes effect mid-cycle. A deasserted reset starts capturing on the next rising edge.
- Clock edge, no reset, flush=1:
  - Load the bubble: pc_w=RESET_PC, valid=0, regwrite=0, memtoreg=0, wa=0.
  - Flush overrides en.
- Clock edge, flush=0, en=1: capture pc_m, opcode_m, byte_m, alu_m, dm_dout_m, memtoreg_m, regwrite_m and wa_m into W registers; valid<=1.
- Clock edge, flush=0, en=0: hold all registers.
- Latency: exactly one clock from M inputs to W outputs. Formatting is combinational from the W registers; no further delay.
- Formatting when memtoreg=1, using the registered word D and byte offset b:
  - lw: D.
  - lb: sign-extend D[8b+7:8b].
  - lbu: zero-extend D[8b+7:8b].
  - lh: sign-extend D[15:0] if b=0, D[31:16] if b=2.
  - lhu: as lh, but zero-extend.
- Formatting when memtoreg=0: wd_w = registered alu.
- Alignment errors:
  - adel_w=1 when memtoreg=1 and either lw with b!=0, or lh/lhu with b odd.
  - On error: wd_w=0 and we_w=0.
- Unknown opcode with memtoreg=1: treat as lw.
- we_w = regwrite & valid & ~adel & (wa!=0). A $0 destination never produces a write enable.
- wd_w is valid in the same cycle as we_w and feeds the forwarding muxes directly.
- Simultaneous en=1 and flush=1: flush wins, and the M instruction is dropped.

Decomposition:
- Shared package: load opcode constants (OP_LW..OP_LHU), the 32'h00003000 text base, and the byte-offset encoding. The store side of the data memory reuses the same constants.
- One natural sub-module, load_ext: purely combinational (opcode, byte, word) -> (data, adel). The top holds the pipeline register only.

Test Plan:
- Assert reset mid-cycle after loading a valid lw. Required immediately, without waiting for a clock edge: we_w=0, pc_w=32'h00003000, valid_w=0.
- dm_dout_m=32'h8899AABB with en=1, one edge per case:
  - lb b=1 -> wd_w=32'hFFFFFFAA.
  - lbu b=3 -> wd_w=32'h00000088.
  - lh b=2 -> wd_w=32'hFFFF8899.
  - lhu b=0 -> wd_w=32'h0000AABB.
- lw b=2, regwrite_m=1, wa_m=5 -> adel_w=1, we_w=0, wd_w=0. lh b=3 gives the same response.
- addu, memtoreg_m=0, alu_m=32'h12345678, wa_m=0 -> wd_w=32'h12345678, we_w=0. Repeat with wa_m=8 -> we_w=1.
- Valid lw in W, then en=0 for 3 edges while the M inputs change -> W outputs stay constant. Then en=1, flush=1 on the same edge -> bubble (valid_w=0, we_w=0).
- Back-to-back lw to regs 2, 3, 4 with en held 1 -> wa_w steps 2, 3, 4 on consecutive edges, each with the matching wd_w and we_w=1.
